// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Decode-side bundle between the decoder/register file and the forwarding and
// hazard controller.
//
// Signals:
//   id_valid            decode holds a valid instruction
//   id_rs, id_rt        source register numbers in decode
//   id_use_rs/rt        instruction reads rs / rt
//   id_use_imm          operand B is the immediate
//   id_wr_en, id_rd     instruction writes register id_rd
//   id_is_load          instruction is a load
//   flush               squash the instruction leaving decode
//   sel_a, sel_b        registered EX operand-mux selects
//   ex_valid            EX holds a real instruction
//   stall               combinational decode stall
//   stall_cnt           saturating stall-cycle counter
//
// Modports:
//   master  decoder side, drives the id_* fields and flush
//   slave   the hazard unit, drives the selects, stall and counter
// -----------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_use_imm;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              flush;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              ex_valid;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
               id_wr_en, id_rd, id_is_load, flush,
        input  sel_a, sel_b, ex_valid, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
               id_wr_en, id_rd, id_is_load, flush,
        output sel_a, sel_b, ex_valid, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard controller for the 5-stage MIPS core.
// Shadows the EX and MEM stages ({valid, wr, rd, load}), computes the operand
// mux selects for the instruction in decode and registers them as it enters EX.
// A load in EX whose result decode needs raises a one-cycle stall and a bubble.
//
// Ports:
//   clk     pipeline clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     fwd_hazard_unit_if.slave (decode fields in, selects/stall out)
//
// Select codes: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback,
//               11 immediate (operand B only).
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fwd_hazard_unit_if.slave     bus
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_EX  = 2'b01,
        SEL_MEM = 2'b10,
        SEL_IMM = 2'b11
    } sel_e;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] rd;
    } slot_t;

    slot_t            r_ex;
    slot_t            r_mem;
    sel_e             r_sel_a;
    sel_e             r_sel_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_stall;
    logic w_advance;
    sel_e w_sel_a;
    sel_e w_sel_b;

    // A slot produces r when it will write a nonzero r; $0 is never forwarded.
    function automatic logic produces(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.wr && (s.rd == r) && (r != '0);
    endfunction

    // EX is checked first: it holds the younger, therefore current, value.
    function automatic sel_e fwd_sel(input slot_t ex, input slot_t mem,
                                     input logic [REG_AW-1:0] r);
        if (produces(ex, r))
            return SEL_EX;
        else if (produces(mem, r))
            return SEL_MEM;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_stall   = 1'b0;
        w_sel_a   = SEL_RF;
        w_sel_b   = SEL_RF;

        // Load result is only available from MEM/WB, so a consumer right
        // behind it waits one cycle. rt of a store-type (imm) op is ignored.
        if (bus.id_valid && !bus.flush && r_ex.valid && r_ex.load &&
            r_ex.wr && (r_ex.rd != '0)) begin
            w_stall = (bus.id_use_rs && (bus.id_rs == r_ex.rd)) ||
                      (bus.id_use_rt && !bus.id_use_imm && (bus.id_rt == r_ex.rd));
        end

        if (bus.id_use_rs)
            w_sel_a = fwd_sel(r_ex, r_mem, bus.id_rs);

        if (bus.id_use_imm)
            w_sel_b = SEL_IMM;
        else if (bus.id_use_rt)
            w_sel_b = fwd_sel(r_ex, r_mem, bus.id_rt);
    end

    assign w_advance = bus.id_valid && !w_stall && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_sel_a     <= SEL_RF;
            r_sel_b     <= SEL_RF;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments make r_mem take the old r_ex,
            // giving a true shift regardless of statement order.
            r_mem <= r_ex;
            if (w_advance) begin
                r_ex    <= '{valid: 1'b1, wr: bus.id_wr_en,
                             load: bus.id_is_load, rd: bus.id_rd};
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end else begin
                r_ex    <= '0;
                r_sel_a <= SEL_RF;
                r_sel_b <= SEL_RF;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.sel_a     = r_sel_a;
    assign bus.sel_b     = r_sel_b;
    assign bus.ex_valid  = r_ex.valid;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed vectors with hand-computed selects, stall and stall counter.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fwd_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) bus ();

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one decode-stage instruction; inputs change just after posedge.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic uimm,
                         input logic wr, input logic [4:0] rd,
                         input logic ld, input logic fl);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_use_rs  = urs;
        bus.id_use_rt  = urt;
        bus.id_use_imm = uimm;
        bus.id_wr_en   = wr;
        bus.id_rd      = rd;
        bus.id_is_load = ld;
        bus.flush      = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("rst_sel_a", bus.sel_a, 2'b00);
        check("rst_sel_b", bus.sel_b, 2'b00);
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_cnt", bus.stall_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back ALU: add $3 ; sub $6,$3,$2 ; op $3,$6
        drive(1, 1, 2, 1, 1, 0, 1, 3, 0, 0);
        step();
        check("first_ex_valid", bus.ex_valid, 1'b1);
        check("first_sel_a", bus.sel_a, 2'b00);
        check("first_sel_b", bus.sel_b, 2'b00);
        drive(1, 3, 2, 1, 1, 0, 1, 6, 0, 0);
        step();
        check("b2b_sel_a_ex", bus.sel_a, 2'b01);
        check("b2b_sel_b_rf", bus.sel_b, 2'b00);
        drive(1, 3, 6, 1, 1, 0, 0, 0, 0, 0);
        step();
        check("gap_sel_a_mem", bus.sel_a, 2'b10);
        check("gap_sel_b_ex", bus.sel_b, 2'b01);

        // Priority: two writers of $5, then reader of $5 on both operands
        drive(1, 1, 0, 1, 0, 0, 1, 5, 0, 0);
        step();
        drive(1, 1, 0, 1, 0, 0, 1, 5, 0, 0);
        step();
        drive(1, 5, 5, 1, 1, 0, 0, 0, 0, 0);
        step();
        check("prio_sel_a", bus.sel_a, 2'b01);
        check("prio_sel_b", bus.sel_b, 2'b01);

        // Register 0 never forwarded
        drive(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 1, 1, 0, 1, 9, 0, 0);
        step();
        check("r0_sel_a", bus.sel_a, 2'b00);
        check("r0_sel_b", bus.sel_b, 2'b00);

        // Immediate overrides dependent rt
        drive(1, 1, 0, 1, 0, 0, 1, 3, 0, 0);
        step();
        drive(1, 1, 3, 1, 1, 1, 1, 7, 0, 0);
        step();
        check("imm_sel_b", bus.sel_b, 2'b11);
        check("imm_sel_a", bus.sel_a, 2'b00);

        // Load-use: lw $4 ; add rs=$4
        drive(1, 1, 0, 1, 0, 1, 1, 4, 1, 0);
        check("lw_no_stall", bus.stall, 1'b0);
        step();
        check("lw_sel_b", bus.sel_b, 2'b11);
        drive(1, 4, 2, 1, 1, 0, 1, 8, 0, 0);
        check("lu_stall", bus.stall, 1'b1);
        step();
        check("lu_bubble", bus.ex_valid, 1'b0);
        check("lu_bubble_sel_a", bus.sel_a, 2'b00);
        check("lu_cnt", bus.stall_cnt, 16'd1);
        check("lu_stall_clear", bus.stall, 1'b0);
        step();
        check("lu_ex_valid", bus.ex_valid, 1'b1);
        check("lu_sel_a_mem", bus.sel_a, 2'b10);
        check("lu_sel_b_rf", bus.sel_b, 2'b00);
        check("lu_cnt_hold", bus.stall_cnt, 16'd1);

        // Flush beats stall; load still advances into MEM
        drive(1, 1, 0, 1, 0, 1, 1, 4, 1, 0);
        step();
        drive(1, 4, 2, 1, 1, 0, 1, 8, 0, 1);
        check("fl_stall", bus.stall, 1'b0);
        step();
        check("fl_bubble", bus.ex_valid, 1'b0);
        check("fl_cnt", bus.stall_cnt, 16'd1);
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        check("fl_after_stall", bus.stall, 1'b0);
        step();
        check("fl_mem_fwd", bus.sel_a, 2'b10);

        // Store with rt depending on a load: no stall
        drive(1, 1, 0, 1, 0, 1, 1, 4, 1, 0);
        step();
        drive(1, 1, 4, 1, 1, 1, 0, 0, 0, 0);
        check("st_no_stall", bus.stall, 1'b0);
        step();
        check("st_ex_valid", bus.ex_valid, 1'b1);
        check("st_sel_b", bus.sel_b, 2'b11);
        check("st_sel_a", bus.sel_a, 2'b00);

        // Reset mid-operation with a load in EX and a stall pending
        drive(1, 1, 0, 1, 0, 1, 1, 4, 1, 0);
        step();
        drive(1, 4, 2, 1, 1, 0, 1, 8, 0, 0);
        check("mid_stall", bus.stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel_b", bus.sel_b, 2'b00);
        check("mid_rst_ex_valid", bus.ex_valid, 1'b0);
        check("mid_rst_stall", bus.stall, 1'b0);
        check("mid_rst_cnt", bus.stall_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("restart_ex_valid", bus.ex_valid, 1'b1);
        check("restart_sel_a", bus.sel_a, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
